// File: rtl/cpu_read_sequencer.sv
// cpu_read_sequencer
// Runs a CPU read transaction as a sequence of single-outstanding memory reads.
// A transaction starts from IDLE on CPU_start. It then issues
// min(num_reads, MAX_READS) reads, one at a time. Each read goes through a
// request/grant handshake and then waits for one READ_complete pulse.
// CPU_end pulses once when the transaction finishes, either normally or after
// a read times out.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (release synchronised to clk)
//   CPU_start     begins a transaction when sampled high in IDLE
//   num_reads     [3:0] reads requested, captured with CPU_start
//   read_req      read request to memory (high only in ISSUE)
//   read_gnt      memory accepts the request this cycle
//   READ_complete one-cycle pulse: data for the outstanding read returned
//   CPU_end       one-cycle pulse: transaction finished
//   busy          high whenever the FSM is not IDLE
//   reads_done    [3:0] completions counted in current/most recent transaction
//   err           sticky protocol/timeout error, cleared only by reset
module cpu_read_sequencer #(
  parameter int MAX_READS = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CPU_start,
  input  logic [3:0] num_reads,
  output logic       read_req,
  input  logic       read_gnt,
  input  logic       READ_complete,
  output logic       CPU_end,
  output logic       busy,
  output logic [3:0] reads_done,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [3:0] MAXR = 4'(MAX_READS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, END} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    target_reg, target_next;
  logic [3:0]    reads_done_reg, reads_done_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          err_reg, err_next;
  logic [3:0]    clamp;

  // Reset assertion is asynchronous, but release passes through two flops.
  // While run_en is low, the FSM is held in its reset values. As a result,
  // the earliest CPU_start that can be accepted is sampled on the third edge
  // after release.
  logic [1:0] rst_sync_reg;
  logic       run_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign run_en = rst_sync_reg[1];
  assign clamp  = (num_reads > MAXR) ? MAXR : num_reads;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      target_reg     <= '0;
      reads_done_reg <= '0;
      tcnt_reg       <= '0;
      err_reg        <= 1'b0;
    end else if (!run_en) begin
      state_reg      <= IDLE;
      target_reg     <= '0;
      reads_done_reg <= '0;
      tcnt_reg       <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      target_reg     <= target_next;
      reads_done_reg <= reads_done_next;
      tcnt_reg       <= tcnt_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    target_next     = target_reg;
    reads_done_next = reads_done_reg;
    tcnt_next       = tcnt_reg;
    err_next        = err_reg;

    // A completion can only be legal while a read is outstanding. This
    // includes a completion that arrives in the same cycle as the grant.
    if (READ_complete && (state_reg != WAIT)) err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (CPU_start) begin
          target_next     = clamp;
          reads_done_next = '0;
          state_next      = (clamp == 4'd0) ? END : ISSUE;
        end
      end
      ISSUE: begin
        if (read_gnt) begin
          state_next = WAIT;
          tcnt_next  = '0;
        end
      end
      WAIT: begin
        // err is raised on the edge where the counter reaches TIMEOUT.
        // The FSM leaves for END one cycle later.
        if (tcnt_reg == TMAX) begin
          state_next = END;
        end else if (READ_complete) begin
          reads_done_next = reads_done_reg + 4'd1;
          state_next      = ((reads_done_reg + 4'd1) == target_reg) ? END : ISSUE;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
          if ((tcnt_reg + TW'(1)) == TMAX) err_next = 1'b1;
        end
      end
      END: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign read_req   = (state_reg == ISSUE);
  assign CPU_end    = (state_reg == END);
  assign busy       = (state_reg != IDLE);
  assign reads_done = reads_done_reg;
  assign err        = err_reg;

endmodule
